pattern_moore: RTL and testbench

- Moore-type serial bit-pattern detector.
- Samples 1-bit input `a` on each rising clock edge. Asserts `y` for one state period whenever the most recent PAT_LEN samples equal PATTERN; overlapping matches are detected.
- `y` is decoded from registered state only; there is no combinational path from `a` to `y`.
- Used as a small FSM building block and as a reference Moore machine for FSM benches.

---
 rtl/pattern_moore.sv | 99 +++++++++
 tb/tb_pattern_moore.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pattern_moore.sv
// pattern_moore -- Moore serial bit-pattern detector.
//
// Samples `a` on every rising edge of clk. The state register holds the
// length of the longest prefix of PATTERN that matches the tail of the
// received stream. `y` is high while that length equals PAT_LEN. Matches may
// overlap, so another match can follow immediately.
//
// Parameters:
//   PAT_LEN  pattern length in bits (1..16)
//   PATTERN  pattern to detect; the MSB is the bit received first
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears the state (and the counter)
//   a          serial data bit
//   y          match flag, decoded from the state register only
//   match_cnt  saturating 8-bit match counter (only with PATTERN_MOORE_COUNT_EN)
//
// Optional feature macro: PATTERN_MOORE_COUNT_EN
module pattern_moore #(
  parameter int                 PAT_LEN = 2,
  parameter logic [PAT_LEN-1:0] PATTERN = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
`ifdef PATTERN_MOORE_COUNT_EN
  output logic [7:0] match_cnt,
`endif
  output logic       y
);

  localparam int SW = $clog2(PAT_LEN + 1);

  typedef enum logic [SW-1:0] {
    S_IDLE  = '0,
    S_MATCH = SW'(PAT_LEN)
  } state_t;

  // Successor of state `st` on input `av`. The stream seen so far is the first
  // st pattern bits followed by av. The result is the longest k for which the
  // last k of those bits equal the first k pattern bits. This function runs at
  // elaboration only, and it builds the transition table below.
  function automatic int calc_next(input int st, input int av);
    int best;
    int idx;
    bit ok;
    bit b;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= st + 1) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          idx = st + 1 - k + i;
          if (idx == st) b = av[0];
          else           b = PATTERN[PAT_LEN-1-idx];
          if (b != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Transition table indexed by [state][a].
  logic [1:0][SW-1:0] nxt_tbl [PAT_LEN+1];

  for (genvar st = 0; st <= PAT_LEN; st++) begin : g_st
    for (genvar av = 0; av < 2; av++) begin : g_a
      localparam int NX = calc_next(st, av);
      assign nxt_tbl[st][av] = SW'(NX);
    end
  end

  state_t s, s_nxt;

  // Encodings above PAT_LEN cannot be reached. If one occurs, fall back to idle.
  always_comb begin
    s_nxt = S_IDLE;
    if (s <= S_MATCH) s_nxt = state_t'(nxt_tbl[s][a]);
  end

  always_ff @(posedge clk) begin
    if (reset) s <= S_IDLE;
    else       s <= s_nxt;
  end

  assign y = (s == S_MATCH);

`ifdef PATTERN_MOORE_COUNT_EN
  // The counter steps on the same edge that enters the match state, so it
  // moves together with y.
  always_ff @(posedge clk) begin
    if (reset)                                  match_cnt <= 8'd0;
    else if (s_nxt == S_MATCH && match_cnt != 8'hFF) match_cnt <= match_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pattern_moore.sv
// Scoreboard bench for pattern_moore. Two instances share the same stimulus:
// one uses the default pattern 01, and one uses 101 with PAT_LEN=3.
// The reference model keeps the sample history since the last reset and
// compares the last PAT_LEN samples with the pattern.
module tb_pattern_moore;

  logic clk = 1'b0;
  logic reset;
  logic a;
  logic y0, y1;
`ifdef PATTERN_MOORE_COUNT_EN
  logic [7:0] cnt0_dut, cnt1_dut;
`endif

  always #5 clk = ~clk;

  pattern_moore u_def (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
`ifdef PATTERN_MOORE_COUNT_EN
    .match_cnt(cnt0_dut),
`endif
    .y        (y0)
  );

  pattern_moore #(.PAT_LEN(3), .PATTERN(3'b101)) u_101 (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
`ifdef PATTERN_MOORE_COUNT_EN
    .match_cnt(cnt1_dut),
`endif
    .y        (y1)
  );

  typedef struct {
    bit y0;
    bit y1;
    int c0;
    int c1;
  } exp_t;

  exp_t sbq[$];
  bit   hist[$];
  int   mcnt0, mcnt1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0] P0 = 16'b01;
  localparam logic [15:0] P1 = 16'b101;

  function automatic bit tail_match(input int len, input logic [15:0] p);
    int n;
    n = hist.size();
    if (n < len) return 1'b0;
    for (int i = 0; i < len; i++)
      if (hist[n-len+i] != p[len-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one sample, update the model at the sampling edge, and queue the
  // expected outputs for the following cycle.
  task automatic step(input bit r, input bit av);
    exp_t e;
    reset = r;
    a     = av;
    @(posedge clk);
    if (r) begin
      hist.delete();
      mcnt0 = 0;
      mcnt1 = 0;
      e.y0 = 1'b0;
      e.y1 = 1'b0;
    end else begin
      hist.push_back(av);
      if (hist.size() > 32) void'(hist.pop_front());
      e.y0 = tail_match(2, P0);
      e.y1 = tail_match(3, P1);
      if (e.y0 && mcnt0 < 255) mcnt0++;
      if (e.y1 && mcnt1 < 255) mcnt1++;
    end
    e.c0 = mcnt0;
    e.c1 = mcnt1;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic seq(input bit r, input int n, input logic [15:0] bits);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(r, v[i]);
  endtask

  // Monitor: the DUT presents y every cycle. Each cycle, pop one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (y0 !== e.y0) begin
        errors++;
        $display("FAIL y_def at %0t: got %b expected %b", $time, y0, e.y0);
      end
      checks++;
      if (y1 !== e.y1) begin
        errors++;
        $display("FAIL y_101 at %0t: got %b expected %b", $time, y1, e.y1);
      end
`ifdef PATTERN_MOORE_COUNT_EN
      checks++;
      if (cnt0_dut !== 8'(e.c0)) begin
        errors++;
        $display("FAIL cnt_def at %0t: got %0d expected %0d", $time, cnt0_dut, e.c0);
      end
      checks++;
      if (cnt1_dut !== 8'(e.c1)) begin
        errors++;
        $display("FAIL cnt_101 at %0t: got %0d expected %0d", $time, cnt1_dut, e.c1);
      end
`endif
    end
  end

  initial begin
    reset = 1'b1;
    a     = 1'b0;
    mcnt0 = 0;
    mcnt1 = 0;
    @(negedge clk);

    // Hold reset for 5 cycles with a=0, then release it with a still 0.
    repeat (5) step(1'b1, 1'b0);
    seq(1'b0, 4, 16'b0000);

    // 1,0,1,1,0,1: default pattern matches after bits 3 and 6.
    step(1'b1, 1'b0);
    seq(1'b0, 6, 16'b101101);

    // All ones: no match on either instance.
    step(1'b1, 1'b0);
    seq(1'b0, 4, 16'b1111);

    // Reset wins over a=1 on the same edge, so the partial match is lost.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    seq(1'b0, 2, 16'b01);

    // 1,0,1,0,1: overlapping 101 matches after bits 3 and 5.
    step(1'b1, 1'b0);
    seq(1'b0, 5, 16'b10101);
    step(1'b0, 1'b0);

    // Random stream with occasional resets.
    step(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 199) == 0), 1'(($urandom >> 3) & 1));

    // Drain the scoreboard, with a bound on the wait.
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
